mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer that shares one unified single-port memory between the fetch-stage instruction requester and the memory-stage data requester of the 5-stage RISC-V pipeline. It holds one transaction outstanding at a time and runs a four-state FSM against a memory with variable grant and response latency. Data requests have priority, with a starvation guard that forces an instruction grant after a bounded number of losses. It returns per-requester response pulses and stall signals that the pipeline uses to freeze its fetch and memory stages.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive lost contested arbitrations before the instruction port is forced to win (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request, held until i_rvalid
- i_addr  in  ADDR_W  instruction address, stable while i_req
- i_rdata  out  DATA_W  instruction read data, valid with i_rvalid
- i_rvalid  out  1  one-cycle instruction response pulse
- i_stall  out  1  stall for the fetch stage
- d_req  in  1  data request, held until d_rvalid
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, valid with d_rvalid
- d_rvalid  out  1  one-cycle data response pulse (also acknowledges writes)
- d_stall  out  1  stall for the memory stage
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_gnt  in  1  memory accepts the request this cycle
- m_rvalid  in  1  memory response or write acknowledge
- m_rdata  in  DATA_W  memory read data

## Operation
- **State machine:** IDLE, REQ, WAIT, RESP; registered owner bit (I or D); latched copies of addr, we and wdata.
- **IDLE:**
  - No request: stay in IDLE.
  - Otherwise select the winner, latch its fields, go to REQ.
  - For the instruction winner, the latched we = 0.
- **Winner selection:**
  - Only one requester active: that requester wins.
  - Both active: D wins unless starve_cnt == STARVE_MAX, in which case I wins.
- **Starvation counter (starve_cnt):**
  - Increments on each IDLE decision where both requested and D won.
  - Clears whenever I is granted.
  - Never exceeds STARVE_MAX.
- **REQ:** m_req = 1 and m_addr/m_we/m_wdata are driven from the latched registers. Go to WAIT on m_gnt; otherwise hold, with fields stable.
- **WAIT:** On m_rvalid, register m_rdata into the owner's rdata output, go to RESP.
- **RESP:**
  - The owner's rvalid is high for exactly one cycle; the other rvalid stays 0.
  - Then go to IDLE.
  - No arbitration happens in RESP; requests sampled in RESP are not acted on until IDLE.
- **Stall outputs (combinational from registered state):**
  - i_stall = i_req & ~(state == RESP & owner == I)
  - d_stall = d_req & ~(state == RESP & owner == D)
- **Ignored inputs:** m_rvalid in IDLE, REQ or RESP is ignored (no response is produced, no state change). m_gnt outside REQ is ignored.
- **Idle outputs:** When m_req = 0, m_we = 0; m_addr and m_wdata hold their last latched values.
- **rdata outputs:** Hold their last value between pulses.

## Timing
- **Reset values (any time, asynchronous):**
  - State = IDLE, owner = I, starve_cnt = 0.
  - m_req, m_we, i_rvalid and d_rvalid = 0.
  - m_addr, m_wdata, i_rdata and d_rdata = 0.
- **Reset mid-transaction:** the outstanding access is abandoned and its late m_rvalid is ignored.
- **Minimum access latency, zero-wait memory:**
  - Cycle 0: IDLE samples the request.
  - Cycle 1: REQ with m_gnt.
  - Cycle 2: WAIT with m_rvalid.
  - Cycle 3: RESP, rvalid pulse.
  - Cycle 4: IDLE again.
  - Back-to-back throughput is one access per 4 cycles.
- Each cycle m_gnt is withheld adds one cycle in REQ. Each cycle m_rvalid is delayed adds one cycle in WAIT.
- Exactly one transaction is outstanding; no pipelining across requesters.

## Test plan
- **Single instruction read:** after reset, i_req = 1, i_addr = 0x40; memory grants immediately and returns 0xDEADBEEF next cycle. Required:
  - m_req high in cycle 1 with m_addr = 0x40, m_we = 0.
  - i_rvalid pulses in cycle 3 with i_rdata = 0xDEADBEEF.
  - i_stall = 1 in cycles 0–2 and 0 in cycle 3.
- **Data write:** d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0x12345678; m_gnt is withheld for 2 cycles. Required:
  - m_req is held for 3 cycles with stable fields.
  - d_rvalid pulses one cycle after m_rvalid.
  - i_rvalid is never asserted.
- **Contention and starvation with STARVE_MAX = 4:** i_req and d_req held high continuously. Required:
  - The grant sequence is D, D, D, D, I, D, D, D, D, I, …
  - starve_cnt never exceeds 4.
- **Simultaneous requests with starve_cnt = 0:** D is granted first; I is granted in the next IDLE after D's RESP, at the earliest 4 cycles later.
- **Spurious m_rvalid:** m_rvalid pulses while in IDLE and while in REQ. Required: no rvalid output and no state change.
- **Reset in WAIT:** rst is pulled low in WAIT, then the memory's late m_rvalid arrives after rst returns high. Required:
  - Immediately: all outputs at their reset values, state IDLE.
  - After reset release: the late m_rvalid is ignored, and a new i_req completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch (I) and memory-stage (D) requesters.
// Latency: 4 cycles minimum per access (IDLE, REQ, WAIT, RESP); +1 per withheld m_gnt / delayed m_rvalid.
// Backpressure: requests are held by the pipeline; the loser and the in-flight owner see their stall high until their rvalid cycle.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   i_req/i_addr      instruction read request (held until i_rvalid)
//   i_rdata/i_rvalid  instruction response, i_stall freezes fetch
//   d_req/d_we/d_addr/d_wdata   data request (held until d_rvalid)
//   d_rdata/d_rvalid  data response (also write acknowledge), d_stall freezes memory stage
//   m_req/m_we/m_addr/m_wdata   request to the shared memory
//   m_gnt/m_rvalid/m_rdata      memory handshake and response
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_stall,

    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t           state;
    logic             owner;
    logic [CNT_W-1:0] starve_cnt;

    // ------------------------------------------------------------------
    // Arbitration (only consumed in IDLE)
    // ------------------------------------------------------------------
    logic             any_req;
    logic             both_req;
    logic             starved;
    logic             pick_d;
    logic [CNT_W-1:0] starve_nxt;

    assign any_req  = i_req | d_req;
    assign both_req = i_req & d_req;
    assign starved  = (starve_cnt == CNT_MAX);

    // D has priority unless the instruction side has already lost
    // STARVE_MAX contested rounds in a row.
    assign pick_d   = d_req & ~(i_req & starved);

    // Only contested losses count against I; any I grant restores it.
    // An uncontested D grant leaves the count untouched.
    always_comb begin
        starve_nxt = starve_cnt;
        if (both_req && pick_d) begin
            if (!starved) begin
                starve_nxt = starve_cnt + CNT_W'(1);
            end
        end else if (i_req && !pick_d) begin
            starve_nxt = '0;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer. m_addr/m_we/m_wdata double as the latched copies of the
    // winning request, so they stay stable for the whole REQ phase and
    // m_addr/m_wdata simply keep their value once the request is taken.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_I;
            starve_cnt <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner      <= pick_d ? OWN_D : OWN_I;
                        starve_cnt <= starve_nxt;
                        m_req      <= 1'b1;
                        m_addr     <= pick_d ? d_addr : i_addr;
                        // Instruction fetches are always reads.
                        m_we       <= pick_d & d_we;
                        if (pick_d) begin
                            m_wdata <= d_wdata;
                        end
                        state      <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (m_gnt) begin
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                        state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // m_rvalid is only meaningful here; elsewhere it is dropped.
                    if (m_rvalid) begin
                        if (owner == OWN_D) begin
                            d_rdata  <= m_rdata;
                            d_rvalid <= 1'b1;
                        end else begin
                            i_rdata  <= m_rdata;
                            i_rvalid <= 1'b1;
                        end
                        state <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // Single-cycle pulse; no arbitration until back in IDLE.
                    i_rvalid <= 1'b0;
                    d_rvalid <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stalls: a requester is released only in its own response cycle.
    // ------------------------------------------------------------------
    logic resp_i;
    logic resp_d;

    assign resp_i  = (state == ST_RESP) && (owner == OWN_I);
    assign resp_d  = (state == ST_RESP) && (owner == OWN_D);
    assign i_stall = i_req & ~resp_i;
    assign d_stall = d_req & ~resp_d;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst)
        !(i_rvalid && d_rvalid));

    a_starve_bound: assert property (@(posedge clk) disable iff (!rst)
        starve_cnt <= CNT_MAX);

    a_req_we_idle: assert property (@(posedge clk) disable iff (!rst)
        !m_req |-> !m_we);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr, m_addr;
    logic [DW-1:0] d_wdata, i_rdata, d_rdata, m_wdata, m_rdata;
    logic          i_rvalid, i_stall, d_rvalid, d_stall;
    logic          m_req, m_we, m_gnt, m_rvalid;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            ph;          // 0 no access owed, 1 waiting to grant, 2 granted, owes response
    int            gw, rvw;
    bit            cap_d, cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    int            scnt;
    bit            arb_cur, resp_prev, was_arb, pend_i, pend_d, pd_we;
    logic [AW-1:0] pi_addr, pd_addr;
    logic [DW-1:0] pd_wdata;
    bit            exp_iv, exp_dv, last_i, last_d;
    logic [DW-1:0] exp_irdata, exp_drdata;
    bit            rand_mode, mem_on, force_spur;
    int            gnt_cfg, rv_cfg, cyc;
    bit            gseq[$];
    int            gcyc[$];
    int            cnt_i, cnt_d, cnt_mreq;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic model_reset();
        ph = 0; scnt = 0; arb_cur = 1; resp_prev = 0;
        exp_iv = 0; exp_dv = 0; last_i = 0; last_d = 0;
        exp_irdata = '0; exp_drdata = '0;
        m_gnt = 0; m_rvalid = 0;
    endtask

    // One clock: snapshot inputs seen at the edge, check outputs after it,
    // then play the memory for the following cycle.
    task automatic cycle();
        bit rising, delivered, own_d;
        was_arb = arb_cur; pend_i = i_req; pend_d = d_req;
        pi_addr = i_addr; pd_addr = d_addr; pd_we = d_we; pd_wdata = d_wdata;
        @(posedge clk); #1; cyc++;

        chk("i_rvalid", i_rvalid, exp_iv);
        chk("d_rvalid", d_rvalid, exp_dv);
        chk("i_rdata", i_rdata, exp_irdata);
        chk("d_rdata", d_rdata, exp_drdata);
        chk("i_stall", i_stall, i_req & ~exp_iv);
        chk("d_stall", d_stall, d_req & ~exp_dv);
        last_i = exp_iv; last_d = exp_dv;

        rising    = was_arb && (pend_i || pend_d);
        arb_cur   = resp_prev || (was_arb && !rising);
        resp_prev = exp_iv || exp_dv;
        exp_iv = 0; exp_dv = 0;

        chk("m_req", m_req, rising || (ph == 1));
        if (!(rising || ph == 1)) chk("m_we_idle", m_we, 1'b0);

        if (rising) begin
            own_d = pend_d && !(pend_i && scnt == SM);
            if (pend_i && pend_d) scnt = own_d ? scnt + 1 : 0;
            else if (pend_i) scnt = 0;
            cap_d = own_d; cap_addr = own_d ? pd_addr : pi_addr;
            cap_we = own_d && pd_we; cap_wdata = pd_wdata;
            chk("m_addr", m_addr, cap_addr);
            chk("m_we", m_we, cap_we);
            if (cap_we) chk("m_wdata", m_wdata, cap_wdata);
            gseq.push_back(m_addr[31]); gcyc.push_back(cyc);
            ph = 1;
            gw = rand_mode ? int'($urandom_range(0, 3)) : gnt_cfg;
        end else if (ph == 1) begin
            chk("m_addr_stable", m_addr, cap_addr);
            chk("m_we_stable", m_we, cap_we);
            if (cap_we) chk("m_wdata_stable", m_wdata, cap_wdata);
        end

        m_gnt = 0; m_rvalid = 0; delivered = 0;
        if (mem_on) begin
            if (ph == 2) begin
                if (rvw == 0) begin
                    m_rvalid = 1;
                    if (cap_we) begin
                        mem[cap_addr] = cap_wdata;
                        m_rdata = $urandom;
                    end else begin
                        m_rdata = mem_rd(cap_addr);
                    end
                    if (cap_d) begin exp_dv = 1; exp_drdata = m_rdata; end
                    else       begin exp_iv = 1; exp_irdata = m_rdata; end
                    ph = 0; delivered = 1;
                end else rvw--;
            end else if (ph == 1) begin
                if (gw == 0) begin
                    m_gnt = 1; ph = 2;
                    rvw = rand_mode ? int'($urandom_range(0, 3)) : rv_cfg;
                end else gw--;
            end
            if (!delivered && ph != 2 && (force_spur || (rand_mode && $urandom_range(0, 5) == 0))) begin
                m_rvalid = 1; m_rdata = $urandom;
            end
            if (ph != 1 && rand_mode && $urandom_range(0, 4) == 0) m_gnt = 1;
        end
    endtask

    task automatic drain(input int max_cyc);
        cnt_i = 0; cnt_d = 0; cnt_mreq = 0;
        for (int k = 0; k < max_cyc; k++) begin
            cycle();
            if (m_req) cnt_mreq++;
            if (last_i) begin cnt_i++; i_req = 0; end
            if (last_d) begin cnt_d++; d_req = 0; end
            if (!i_req && !d_req) break;
        end
        chk("drain_done", {i_req, d_req}, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stopping;
        rst = 0; i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        m_rdata = '0; rand_mode = 0; mem_on = 1; force_spur = 0; gnt_cfg = 0; rv_cfg = 0; cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_m_we", m_we, 1'b0);
        chk("rst_m_addr", m_addr, '0);
        chk("rst_m_wdata", m_wdata, '0);
        chk("rst_i_rvalid", i_rvalid, 1'b0);
        chk("rst_d_rvalid", d_rvalid, 1'b0);
        chk("rst_i_rdata", i_rdata, '0);
        chk("rst_d_rdata", d_rdata, '0);
        rst = 1;

        // Single instruction read, zero-wait memory
        mem[32'h40] = 32'hDEAD_BEEF;
        i_addr = 32'h40; i_req = 1; #1;
        chk("t1_stall_c0", i_stall, 1'b1);
        cycle();
        chk("t1_mreq_c1", m_req, 1'b1);
        chk("t1_maddr_c1", m_addr, 32'h40);
        chk("t1_mwe_c1", m_we, 1'b0);
        chk("t1_stall_c1", i_stall, 1'b1);
        cycle();
        chk("t1_stall_c2", i_stall, 1'b1);
        cycle();
        chk("t1_rvalid_c3", i_rvalid, 1'b1);
        chk("t1_rdata_c3", i_rdata, 32'hDEAD_BEEF);
        chk("t1_stall_c3", i_stall, 1'b0);
        i_req = 0;
        cycle();
        chk("t1_rvalid_c4", i_rvalid, 1'b0);

        // Data write with m_gnt withheld two cycles, then read it back
        gnt_cfg = 2; rv_cfg = 0;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h1234_5678;
        drain(30);
        chk("t2_mreq_cycles", cnt_mreq, 3);
        chk("t2_d_pulses", cnt_d, 1);
        chk("t2_i_pulses", cnt_i, 0);
        gnt_cfg = 0;
        d_req = 1; d_we = 0; d_addr = 32'h100;
        drain(30);
        chk("t2_readback", d_rdata, 32'h1234_5678);

        // Spurious m_rvalid in IDLE and in REQ
        force_spur = 1;
        repeat (3) cycle();
        gnt_cfg = 3; rv_cfg = 0;
        i_addr = 32'h44; i_req = 1;
        drain(30);
        chk("t3_mreq_cycles", cnt_mreq, 4);
        chk("t3_i_pulses", cnt_i, 1);
        force_spur = 0; gnt_cfg = 0;

        // Contention: both held continuously
        gseq.delete(); gcyc.delete(); stopping = 0;
        i_addr = 32'h200; d_addr = 32'h8000_0300; d_we = 0;
        i_req = 1; d_req = 1;
        for (int k = 0; k < 200; k++) begin
            cycle();
            if (gseq.size() >= 10) stopping = 1;
            if (last_i) begin if (stopping) i_req = 0; else i_addr = i_addr + 4; end
            if (last_d) begin if (stopping) d_req = 0; else d_addr = d_addr + 4; end
            if (stopping && !i_req && !d_req) break;
        end
        chk("t4_done", {i_req, d_req}, 2'b00);
        if (gseq.size() >= 10) begin
            for (int g = 0; g < 10; g++) chk($sformatf("t4_grant%0d", g), gseq[g], (g % 5 == 4) ? 1'b0 : 1'b1);
            chk("t4_first_gap", gcyc[1] - gcyc[0], 4);
        end else chk("t4_grant_count", gseq.size(), 10);

        // Reset while in WAIT, then a late m_rvalid
        rv_cfg = 10;
        i_addr = 32'h80; i_req = 1;
        cycle(); cycle(); cycle();
        #1 rst = 0; #1;
        chk("t5_m_req", m_req, 1'b0);
        chk("t5_m_addr", m_addr, '0);
        chk("t5_i_rvalid", i_rvalid, 1'b0);
        chk("t5_i_rdata", i_rdata, '0);
        chk("t5_d_rdata", d_rdata, '0);
        chk("t5_i_stall", i_stall, 1'b1);
        i_req = 0;
        @(posedge clk); #2 rst = 1;
        model_reset();
        mem_on = 0; m_rvalid = 1; m_rdata = 32'hBAD0_BAD0;
        cycle();
        cycle(); cycle();
        mem_on = 1; rv_cfg = 1;
        i_addr = 32'h84; i_req = 1;
        drain(30);
        chk("t5_new_pulse", cnt_i, 1);
        chk("t5_new_rdata", i_rdata, mem_rd(32'h84));

        // Randomized traffic with random latencies and spurious handshakes
        rand_mode = 1; gseq.delete(); gcyc.delete();
        for (int k = 0; k < 3000; k++) begin
            cycle();
            if (last_i) i_req = 0;
            if (last_d) d_req = 0;
            if (!i_req && $urandom_range(0, 3) == 0) begin
                i_req = 1; i_addr = $urandom & 32'h7FFF_FFFC;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = $urandom_range(0, 1);
                d_addr = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
                d_wdata = $urandom;
            end
        end
        drain(100);
        chk("rand_activity", gseq.size() > 100, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
